// File: rtl/ca_pkg.sv
// Shared constants, state encoding and rule lookup
// for the cellular-automaton line writer.
package ca_pkg;

  localparam int WIDTH = 80;
  localparam int ROWS  = 60;
  localparam int RW    = 7;

  typedef enum logic [1:0] {
    COMMIT,
    IDLE,
    CALC
  } state_t;

  function automatic logic rule_bit(
    input logic [7:0] r,
    input logic [2:0] nb
  );
    return r[nb];
  endfunction

endpackage

// File: rtl/ca_line_writer.sv
// Bit-serial 1-D cellular automaton generator that
// feeds the frame-buffer write port, one line per start.
module ca_line_writer #(
  parameter int WIDTH    = ca_pkg::WIDTH,
  parameter int ROWS     = ca_pkg::ROWS,
  parameter int SEED_COL = 40
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [7:0]             rule,
  input  logic [ca_pkg::RW-1:0]  row,
  output logic [ca_pkg::RW-1:0]  rowW,
  output logic [WIDTH-1:0]       dataW,
  output logic                   busy,
  output logic [ca_pkg::RW-1:0]  top_row
);
  import ca_pkg::*;

  localparam logic [WIDTH-1:0] SEED =
    {{(WIDTH-1){1'b0}}, 1'b1} << SEED_COL;
  localparam logic [6:0] LAST = 7'(WIDTH-1);
  localparam logic [RW-1:0] RLAST = RW'(ROWS-1);

  state_t            state;
  logic [WIDTH-1:0]  cur;
  logic [WIDTH-1:0]  nxt;
  logic [WIDTH-1:0]  line;
  logic [6:0]        col;
  logic [6:0]        lc;
  logic [6:0]        rc;
  logic [RW-1:0]     wr_row;
  logic [RW-1:0]     wr_nx;
  logic [7:0]        rule_q;
  logic              full;

  // line = nxt with the current column folded in,
  // so the last column lands in cur without a bubble
  always_comb begin
    lc   = (col == 7'd0) ? LAST : col - 7'd1;
    rc   = (col == LAST) ? 7'd0 : col + 7'd1;
    line = nxt;
    line[col] = rule_bit(rule_q, {cur[lc], cur[col], cur[rc]});
    wr_nx = (wr_row == RLAST) ? '0 : wr_row + RW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= COMMIT;
      cur     <= SEED;
      nxt     <= '0;
      wr_row  <= '0;
      rowW    <= '0;
      dataW   <= SEED;
      busy    <= 1'b1;
      top_row <= '0;
      full    <= 1'b0;
      col     <= '0;
      rule_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rule_q <= rule;
            col    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          nxt <= line;
          if (col == LAST) begin
            cur    <= line;
            dataW  <= line;
            wr_row <= wr_nx;
            rowW   <= wr_nx;
            if (wr_row == RLAST) full <= 1'b1;
            state  <= COMMIT;
          end else begin
            col <= col + 7'd1;
          end
        end
        COMMIT: begin
          // the buffer drops writes aimed at its read row
          if (row != wr_row) begin
            busy    <= 1'b0;
            state   <= IDLE;
            top_row <= full ? wr_nx : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
